drr_distributor: RTL
====================

Name: drr_distributor

Overview:
- Transmit-side counterpart of the receive-path DRR merge scheduler.
- Takes one AXI-Stream packet source and spreads whole packets across IF_COUNT output interfaces using Deficit Round Robin, weighted by packet length.
- Switching is packet-atomic: no interleaving of beats from different packets.
- Sits between the data-processing core and the per-interface TX FIFOs.

Parameters:
IF_COUNT, 3, number of output interfaces (2..8)
DATA_WIDTH, 64, tdata width
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
QUANTUM, 1500, credit (bytes) added to a port once per round-robin visit
PKT_LEN_WIDTH, 16, packet length width; deficit counters are PKT_LEN_WIDTH+1 bits

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_axis_tdata  in  DATA_WIDTH  input data
s_axis_tkeep  in  KEEP_WIDTH  input byte enables
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  end of packet
s_pkt_len  in  PKT_LEN_WIDTH  byte length of the current packet; valid while the first beat is presented
cfg_port_en  in  IF_COUNT  per-port enable mask
m_axis_tdata  out  IF_COUNT*DATA_WIDTH  data, same value broadcast to every port slice
m_axis_tkeep  out  IF_COUNT*KEEP_WIDTH  keep, broadcast to every port slice
m_axis_tvalid  out  IF_COUNT  per-port valid; at most one bit set
m_axis_tready  in  IF_COUNT  per-port ready
m_axis_tlast  out  IF_COUNT  per-port last
cur_sel  out  $clog2(IF_COUNT)  port owning the current or last packet
busy  out  1  high in ARB or FWD

Behaviour:
- Reset:
  - state=IDLE; ptr=0; cur_sel=0; credited=0; all deficits=0; len_q=0.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, busy=0.
  - A reset mid-packet abandons the packet; the remaining beats are treated as a new packet.
- IDLE:
  - s_axis_tready=0.
  - On s_axis_tvalid: latch cost len_q=max(s_pkt_len,1), then go to ARB.
- ARB: s_axis_tready=0; exactly one evaluation of ptr per cycle, in this priority order:
  1. !cfg_port_en[ptr]: deficit[ptr]<=0, credited<=0, ptr<=(ptr+1)%IF_COUNT.
  2. deficit[ptr]>=len_q: deficit[ptr]<=deficit[ptr]-len_q, cur_sel<=ptr, go to FWD. ptr and credited are unchanged, so the same visit may serve further packets.
  3. !credited: deficit[ptr]<=min(deficit[ptr]+QUANTUM, 2^(PKT_LEN_WIDTH+1)-1), credited<=1, stay on ptr.
  4. Otherwise: credited<=0, ptr<=(ptr+1)%IF_COUNT.
- All ports disabled: ARB cycles ptr indefinitely, deficits stay 0, input is stalled. Enabling any port resumes arbitration.
- FWD: combinational pass-through, zero added latency per beat.
  - m_axis_tvalid[cur_sel]=s_axis_tvalid; other tvalid bits are 0.
  - m_axis_tlast[cur_sel]=s_axis_tlast.
  - s_axis_tready=m_axis_tready[cur_sel].
  - Beat accepted with tlast: go to IDLE next cycle.
  - cfg_port_en changes during FWD do not affect the current packet.
- Latency: first beat can be forwarded no earlier than 2 cycles after s_axis_tvalid rises (IDLE, ARB). A packet needing one credit step takes 3 cycles.
- s_pkt_len is sampled only in IDLE; later changes are ignored.
- Deficit arithmetic is unsigned; subtraction never underflows because of the check in rule 2.
- Oversize packets (len > QUANTUM) accumulate credit over successive visits until served.

Test Plan:
1. IF_COUNT=3, all enabled, QUANTUM=1500, six 1000-byte packets -> ports 0,1,2,0,0,1; final deficits {0,1000,500}.
2. cfg_port_en=3'b101, five 1000-byte packets -> ports 0,2,0,0,2; deficit[1] stays 0.
3. 8-beat packet to port 0; hold m_axis_tready[0]=0 for beats 3-5 -> s_axis_tready=0 over those cycles, all beats delivered in order with no loss or duplication, m_axis_tvalid[2:1]=0 throughout.
4. Only port 0 enabled, one 4000-byte packet -> served after the third credit (deficit 4500), deficit[0]=500 afterwards.
5. Assert rst for one cycle during beat 4 of a packet -> next cycle all m_axis_tvalid=0, s_axis_tready=0, deficits 0; next packet goes to port 0.
6. cfg_port_en=0 with s_axis_tvalid high for 20 cycles -> s_axis_tready stays 0. Then set cfg_port_en=3'b100 -> packet forwarded on port 2 only.

Source files
------------

// File: rtl/drr_distributor_if.sv
// Stream bundle for the DRR distributor: one packet source side and IF_COUNT sink slices.
// The slave modport is the distributor's view; master is the surrounding logic's view.
interface drr_distributor_if #(
    parameter int IF_COUNT      = 3,
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int PKT_LEN_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]          s_axis_tdata;
    logic [KEEP_WIDTH-1:0]          s_axis_tkeep;
    logic                           s_axis_tvalid;
    logic                           s_axis_tready;
    logic                           s_axis_tlast;
    logic [PKT_LEN_WIDTH-1:0]       s_pkt_len;
    logic [IF_COUNT*DATA_WIDTH-1:0] m_axis_tdata;
    logic [IF_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep;
    logic [IF_COUNT-1:0]            m_axis_tvalid;
    logic [IF_COUNT-1:0]            m_axis_tready;
    logic [IF_COUNT-1:0]            m_axis_tlast;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_pkt_len,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_pkt_len,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/drr_distributor.sv
// Deficit Round Robin packet distributor: spreads whole packets from one stream
// across IF_COUNT output ports, weighting each port's share by packet length.
module drr_distributor #(
    parameter int IF_COUNT      = 3,
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int QUANTUM       = 1500,
    parameter int PKT_LEN_WIDTH = 16,
    localparam int SEL_W        = $clog2(IF_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    drr_distributor_if.slave     axis,
    input  logic [IF_COUNT-1:0]  cfg_port_en,
    output logic [SEL_W-1:0]     cur_sel,
    output logic                 busy
);
    localparam int DEF_W = PKT_LEN_WIDTH + 1;
    localparam logic [DEF_W-1:0] DEF_MAX     = {DEF_W{1'b1}};
    localparam logic [DEF_W:0]   QUANTUM_EXT = (DEF_W + 1)'(QUANTUM);
    localparam logic [SEL_W-1:0] LAST_PORT   = SEL_W'(IF_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_FWD  = 2'd2
    } state_t;

    state_t                   state_r, state_s;
    logic [SEL_W-1:0]         ptr_r, ptr_s;
    logic [SEL_W-1:0]         cur_sel_r, cur_sel_s;
    logic                     credited_r, credited_s;
    logic [PKT_LEN_WIDTH-1:0] len_q_r, len_q_s;
    logic [DEF_W-1:0]         deficit_r [IF_COUNT];
    logic [DEF_W-1:0]         deficit_s [IF_COUNT];
    logic                     busy_r;

    logic [DEF_W-1:0]         cur_def_s;
    logic                     ptr_en_s;
    logic                     sel_ready_s;
    logic                     def_wr_s;
    logic [DEF_W-1:0]         def_new_s;

    // Credit top-up saturates instead of wrapping so an idle port never loses its share.
    function automatic logic [DEF_W-1:0] sat_add_quantum(input logic [DEF_W-1:0] d);
        logic [DEF_W:0] sum;
        sum = {1'b0, d} + QUANTUM_EXT;
        return (sum > {1'b0, DEF_MAX}) ? DEF_MAX : sum[DEF_W-1:0];
    endfunction

    function automatic logic [SEL_W-1:0] next_port(input logic [SEL_W-1:0] p);
        return (p == LAST_PORT) ? {SEL_W{1'b0}} : p + SEL_W'(1'b1);
    endfunction

    // Per-port views selected by the round-robin pointer and by the owning port.
    always_comb begin
        cur_def_s   = {DEF_W{1'b0}};
        ptr_en_s    = 1'b0;
        sel_ready_s = 1'b0;
        for (int i = 0; i < IF_COUNT; i++) begin
            cur_def_s   = (ptr_r == SEL_W'(i)) ? deficit_r[i] : cur_def_s;
            ptr_en_s    = (ptr_r == SEL_W'(i)) ? cfg_port_en[i] : ptr_en_s;
            sel_ready_s = (cur_sel_r == SEL_W'(i)) ? axis.m_axis_tready[i] : sel_ready_s;
        end
    end

    // Next-state logic: one DRR evaluation of the pointed port per ARB cycle.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        cur_sel_s  = cur_sel_r;
        credited_s = credited_r;
        len_q_s    = len_q_r;
        def_wr_s   = 1'b0;
        def_new_s  = cur_def_s;
        case (state_r)
            ST_IDLE: begin
                if (axis.s_axis_tvalid) begin
                    len_q_s = (axis.s_pkt_len == {PKT_LEN_WIDTH{1'b0}}) ?
                              PKT_LEN_WIDTH'(1'b1) : axis.s_pkt_len;
                    state_s = ST_ARB;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (!ptr_en_s) begin
                    def_wr_s   = 1'b1;
                    def_new_s  = {DEF_W{1'b0}};
                    credited_s = 1'b0;
                    ptr_s      = next_port(ptr_r);
                end else if (cur_def_s >= {1'b0, len_q_r}) begin
                    // Pointer and credited flag stay put so this visit can serve more packets.
                    def_wr_s  = 1'b1;
                    def_new_s = cur_def_s - {1'b0, len_q_r};
                    cur_sel_s = ptr_r;
                    state_s   = ST_FWD;
                end else if (!credited_r) begin
                    def_wr_s   = 1'b1;
                    def_new_s  = sat_add_quantum(cur_def_s);
                    credited_s = 1'b1;
                end else begin
                    credited_s = 1'b0;
                    ptr_s      = next_port(ptr_r);
                end
            end
            ST_FWD: begin
                if (axis.s_axis_tvalid && sel_ready_s && axis.s_axis_tlast) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FWD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        for (int i = 0; i < IF_COUNT; i++) begin
            deficit_s[i] = (def_wr_s && (ptr_r == SEL_W'(i))) ? def_new_s : deficit_r[i];
        end
    end

    // State and scheduler registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {SEL_W{1'b0}};
            cur_sel_r  <= {SEL_W{1'b0}};
            credited_r <= 1'b0;
            len_q_r    <= {PKT_LEN_WIDTH{1'b0}};
            busy_r     <= 1'b0;
            for (int i = 0; i < IF_COUNT; i++) begin
                deficit_r[i] <= {DEF_W{1'b0}};
            end
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            cur_sel_r  <= cur_sel_s;
            credited_r <= credited_s;
            len_q_r    <= len_q_s;
            busy_r     <= (state_s != ST_IDLE);
            for (int i = 0; i < IF_COUNT; i++) begin
                deficit_r[i] <= deficit_s[i];
            end
        end
    end

    // Zero-latency beat path: data is broadcast, handshake goes only to the owning port.
    always_comb begin
        axis.m_axis_tdata  = {IF_COUNT{axis.s_axis_tdata}};
        axis.m_axis_tkeep  = {IF_COUNT{axis.s_axis_tkeep}};
        axis.m_axis_tvalid = {IF_COUNT{1'b0}};
        axis.m_axis_tlast  = {IF_COUNT{1'b0}};
        for (int i = 0; i < IF_COUNT; i++) begin
            axis.m_axis_tvalid[i] = ((state_r == ST_FWD) && (cur_sel_r == SEL_W'(i))) ?
                                    axis.s_axis_tvalid : 1'b0;
            axis.m_axis_tlast[i]  = ((state_r == ST_FWD) && (cur_sel_r == SEL_W'(i))) ?
                                    axis.s_axis_tlast : 1'b0;
        end
        axis.s_axis_tready = (state_r == ST_FWD) ? sel_ready_s : 1'b0;
    end

    assign cur_sel = cur_sel_r;
    assign busy    = busy_r;
endmodule
